// File: rtl/sigma_bus_pkg.sv
// sigma_bus_pkg: shared types and constants for the sigma system-bus arbiter
// and related blocks.
//   arb_state_e    - arbiter state (IDLE, REQ, RESP)
//   bus_t          - native 32/32 sigma bus request bundle (req, we, addr, be, wdata)
//   BUS_ERR_RDATA  - read data returned to a master whose read was aborted
//   ptr_width()    - width of a round-robin pointer for n masters (min 1 bit)
package sigma_bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  localparam logic [31:0] BUS_ERR_RDATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [BUS_AW-1:0]     addr;
    logic [BUS_DW/8-1:0]   be;
    logic [BUS_DW-1:0]     wdata;
  } bus_t;

  // A single master still needs a 1-bit pointer so the vectors stay legal.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sigma_rr_picker.sv
// sigma_rr_picker: combinational round-robin selector. Scans req_i upward
// starting at ptr_i, wrapping at N-1 back to 0, and returns the first set bit.
// Shared with the interrupt controller.
// Parameters:
//   N   - number of request lines
//   PW  - pointer width (defaults to ptr_width(N))
// Ports:
//   req_i   in  N   request vector
//   ptr_i   in  PW  first position to consider
//   gnt_o   out N   one-hot selection, 0 when nothing requests
//   idx_o   out PW  index of the selection (0 when nothing requests)
//   valid_o out 1   some request was selected
module sigma_rr_picker
  import sigma_bus_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  int k;

  // ptr_i < N and i < N, so a single subtraction is enough to wrap k;
  // this keeps the scan correct when N is not a power of two.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr_i) + i;
      if (k >= N) begin
        k = k - N;
      end
      if (!valid_o && req_i[k]) begin
        gnt_o[k] = 1'b1;
        idx_o    = PW'(k);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sigma_bus_arb.sv
// sigma_bus_arb: round-robin arbiter sharing the single sigma system-bus slave
// port between NM masters. A grant is held until the transaction completes:
// writes finish on the slave ack, reads finish on the slave response.
//
// Optional feature (macro SIGMA_BUS_ARB_TIMEOUT_EN): read-response watchdog.
// After TIMEOUT RESP cycles without s_resp_i the read is answered with
// BUS_ERR_RDATA, err_o pulses and the grant is released. Without the macro
// the arbiter waits indefinitely and err_o is 0.
//
// Parameters: NM masters (2..8), AW address width, DW data width, TIMEOUT.
// Ports:
//   clk_i, arst_i                 clock, asynchronous active-high reset
//   m_req_i/m_we_i [NM]           per-master request / write enable
//   m_addr_i  [NM*AW]             packed, master k at [k*AW +: AW]
//   m_be_i    [NM*DW/8]           packed byte enables
//   m_wdata_i [NM*DW]             packed write data
//   m_ack_o/m_resp_o [NM]         per-master accept / read-data-valid
//   m_rdata_o [DW]                read data broadcast to all masters
//   s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o   slave-side request
//   s_ack_i, s_resp_i, s_rdata_i  slave accept / response / read data
//   grant_o [NM]                  one-hot owner, 0 when idle
//   err_o                         watchdog abort pulse
module sigma_bus_arb
  import sigma_bus_pkg::*;
#(
  parameter int NM      = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic [NM-1:0]      m_req_i,
  input  logic [NM-1:0]      m_we_i,
  input  logic [NM*AW-1:0]   m_addr_i,
  input  logic [NM*DW/8-1:0] m_be_i,
  input  logic [NM*DW-1:0]   m_wdata_i,
  output logic [NM-1:0]      m_ack_o,
  output logic [NM-1:0]      m_resp_o,
  output logic [DW-1:0]      m_rdata_o,
  output logic               s_req_o,
  output logic               s_we_o,
  output logic [AW-1:0]      s_addr_o,
  output logic [DW/8-1:0]    s_be_o,
  output logic [DW-1:0]      s_wdata_o,
  input  logic               s_ack_i,
  input  logic               s_resp_i,
  input  logic [DW-1:0]      s_rdata_i,
  output logic [NM-1:0]      grant_o,
  output logic               err_o
);

  localparam int PW = ptr_width(NM);
  localparam int BW = DW / 8;

  arb_state_e    state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [NM-1:0] grant_q, grant_d;
  logic [PW-1:0] gidx_q, gidx_d;

  logic [NM-1:0] pick_gnt;
  logic [PW-1:0] pick_idx;
  logic          pick_valid;

  logic          gnt_req;
  logic [PW-1:0] next_ptr;
  logic          abort;

  sigma_rr_picker #(
    .N  (NM),
    .PW (PW)
  ) u_picker (
    .req_i   (m_req_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign gnt_req  = m_req_i[gidx_q];
  // Explicit wrap so NM need not be a power of two.
  assign next_ptr = (gidx_q == PW'(NM - 1)) ? '0 : gidx_q + PW'(1);
  assign grant_o  = grant_q;

`ifdef SIGMA_BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [DW-1:0] ERR_RDATA = DW'(BUS_ERR_RDATA);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter is held at 0 during REQ so the first RESP cycle sees 0.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == REQ) begin
      cnt_d = '0;
    end else if (state_q == RESP) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A real response in the limit cycle wins over the abort.
  assign abort = (state_q == RESP) && !s_resp_i && (cnt_q == CW'(TIMEOUT - 1));
  assign err_o = abort;
`else
  assign abort = 1'b0;
  assign err_o = 1'b0;
`endif

  // Next-state logic. A granted master dropping req before ack is a
  // protocol violation: release without advancing the pointer.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!gnt_req) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (s_ack_i) begin
          if (m_we_i[gidx_q]) begin
            grant_d  = '0;
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (s_resp_i || abort) begin
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      gidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
    end
  end

  // Slave-side mux and per-master handshakes are combinational from the
  // registered state, so reset clears them immediately.
  always_comb begin
    s_req_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_be_o    = '0;
    s_wdata_o = '0;
    m_ack_o   = '0;
    m_resp_o  = '0;
    m_rdata_o = '0;
    if (state_q == REQ) begin
      s_req_o   = gnt_req;
      s_we_o    = m_we_i[gidx_q];
      s_addr_o  = m_addr_i[int'(gidx_q) * AW +: AW];
      s_be_o    = m_be_i[int'(gidx_q) * BW +: BW];
      s_wdata_o = m_wdata_i[int'(gidx_q) * DW +: DW];
      m_ack_o   = grant_q & {NM{s_ack_i & gnt_req}};
    end
    if (state_q == RESP) begin
      m_resp_o  = grant_q & {NM{s_resp_i | abort}};
`ifdef SIGMA_BUS_ARB_TIMEOUT_EN
      m_rdata_o = abort ? ERR_RDATA : s_rdata_i;
`else
      m_rdata_o = s_rdata_i;
`endif
    end
  end

endmodule

// File: tb/tb_sigma_bus_arb.sv
// tb_sigma_bus_arb: directed self-checking bench for sigma_bus_arb with two
// masters. Covers reset, single write, read, contention, protocol violation,
// reset mid-read and (with SIGMA_BUS_ARB_TIMEOUT_EN) the read watchdog.
module tb_sigma_bus_arb;
  import sigma_bus_pkg::*;

  localparam int NM         = 2;
  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int TB_TIMEOUT = 16;

  logic               clk_i = 1'b0;
  logic               arst_i;
  logic [NM-1:0]      m_req_i;
  logic [NM-1:0]      m_we_i;
  logic [NM*AW-1:0]   m_addr_i;
  logic [NM*DW/8-1:0] m_be_i;
  logic [NM*DW-1:0]   m_wdata_i;
  logic [NM-1:0]      m_ack_o;
  logic [NM-1:0]      m_resp_o;
  logic [DW-1:0]      m_rdata_o;
  logic               s_req_o;
  logic               s_we_o;
  logic [AW-1:0]      s_addr_o;
  logic [DW/8-1:0]    s_be_o;
  logic [DW-1:0]      s_wdata_o;
  logic               s_ack_i;
  logic               s_resp_i;
  logic [DW-1:0]      s_rdata_i;
  logic [NM-1:0]      grant_o;
  logic               err_o;

  int num_checks = 0;
  int num_passed = 0;
  bus_t exp_bus;

  sigma_bus_arb #(
    .NM      (NM),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .m_req_i   (m_req_i),
    .m_we_i    (m_we_i),
    .m_addr_i  (m_addr_i),
    .m_be_i    (m_be_i),
    .m_wdata_i (m_wdata_i),
    .m_ack_o   (m_ack_o),
    .m_resp_o  (m_resp_o),
    .m_rdata_o (m_rdata_o),
    .s_req_o   (s_req_o),
    .s_we_o    (s_we_o),
    .s_addr_o  (s_addr_o),
    .s_be_o    (s_be_o),
    .s_wdata_o (s_wdata_o),
    .s_ack_i   (s_ack_i),
    .s_resp_i  (s_resp_i),
    .s_rdata_i (s_rdata_i),
    .grant_o   (grant_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Counts one comparison and reports it if the DUT disagrees.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    num_checks++;
    if (observed === expected) begin
      num_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one master's request fields.
  task automatic applyStimulus(input int k, input logic req, input logic we,
                               input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata);
    m_req_i[k]              = req;
    m_we_i[k]               = we;
    m_addr_i[k*AW +: AW]    = addr;
    m_be_i[k*DW/8 +: DW/8]  = be;
    m_wdata_i[k*DW +: DW]   = wdata;
  endtask

  // Inputs change 2 time units after the active edge.
  task automatic cycle();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    arst_i    = 1'b1;
    m_req_i   = '0;
    m_we_i    = '0;
    m_addr_i  = '0;
    m_be_i    = '0;
    m_wdata_i = '0;
    s_ack_i   = 1'b0;
    s_resp_i  = 1'b0;
    s_rdata_i = '0;

    // Reset state
    #3;
    checkOutput("rst_grant", grant_o, 0);
    checkOutput("rst_s_req", s_req_o, 0);
    checkOutput("rst_ack", m_ack_o, 0);
    checkOutput("rst_resp", m_resp_o, 0);
    checkOutput("rst_rdata", m_rdata_o, 0);
    checkOutput("rst_err", err_o, 0);
    cycle();
    cycle();
    arst_i = 1'b0;

    // Single write from m0, ack in the second REQ cycle
    exp_bus = '{req: 1'b1, we: 1'b1, addr: 32'h100, be: 4'hF, wdata: 32'h12345678};
    applyStimulus(0, 1'b1, 1'b1, 32'h100, 4'hF, 32'h12345678);
    #1;
    checkOutput("wr_s_req_lat0", s_req_o, 0);
    cycle(); #1;
    checkOutput("wr_s_req", s_req_o, exp_bus.req);
    checkOutput("wr_grant", grant_o, 2'b01);
    checkOutput("wr_s_we", s_we_o, exp_bus.we);
    checkOutput("wr_s_addr", s_addr_o, exp_bus.addr);
    checkOutput("wr_s_be", s_be_o, exp_bus.be);
    checkOutput("wr_s_wdata", s_wdata_o, exp_bus.wdata);
    checkOutput("wr_no_ack_yet", m_ack_o, 0);
    cycle();
    s_ack_i = 1'b1;
    #1;
    checkOutput("wr_ack", m_ack_o, 2'b01);
    cycle();
    s_ack_i = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    checkOutput("wr_grant_idle", grant_o, 0);
    checkOutput("wr_ack_idle", m_ack_o, 0);

    // Both request: pointer is now 1, so m1 (read) must win
    applyStimulus(0, 1'b1, 1'b1, 32'h300, 4'hF, 32'hAAAA5555);
    applyStimulus(1, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0);
    cycle(); #1;
    checkOutput("rd_grant_rr1", grant_o, 2'b10);
    checkOutput("rd_s_addr", s_addr_o, 32'h200);
    checkOutput("rd_s_we", s_we_o, 0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    s_ack_i = 1'b1;
    #1;
    checkOutput("rd_ack", m_ack_o, 2'b10);
    cycle();
    s_ack_i = 1'b0;
    #1;
    checkOutput("rd_resp_s_req", s_req_o, 0);
    checkOutput("rd_resp_grant", grant_o, 2'b10);
    checkOutput("rd_resp_wait0", m_resp_o, 0);
    cycle();
    cycle(); #1;
    checkOutput("rd_resp_wait2", m_resp_o, 0);
    cycle();
    s_resp_i  = 1'b1;
    s_rdata_i = 32'hCAFEF00D;
    #1;
    checkOutput("rd_resp", m_resp_o, 2'b10);
    checkOutput("rd_rdata", m_rdata_o, 32'hCAFEF00D);
    cycle();
    s_resp_i  = 1'b0;
    s_rdata_i = '0;
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    checkOutput("rd_grant_idle", grant_o, 0);
    checkOutput("rd_resp_idle", m_resp_o, 0);

    // Contention: pointer is back at 0, grants alternate m0, m1, ...
    applyStimulus(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'h11111111);
    applyStimulus(1, 1'b1, 1'b1, 32'h20, 4'hF, 32'h22222222);
    for (int t = 0; t < 8; t++) begin
      int w = 0;
      while (grant_o == 0 && w < 10) begin
        cycle(); #1;
        w++;
      end
      checkOutput("cont_grant", grant_o, (t % 2 == 0) ? 2'b01 : 2'b10);
      s_ack_i = 1'b1;
      #1;
      checkOutput("cont_ack", m_ack_o, (t % 2 == 0) ? 2'b01 : 2'b10);
      cycle();
      s_ack_i = 1'b0;
    end
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    checkOutput("cont_err", err_o, 0);

    // Protocol violation: m0 drops req while in REQ
    applyStimulus(0, 1'b1, 1'b1, 32'h400, 4'h3, 32'h0BADF00D);
    cycle(); #1;
    checkOutput("viol_grant", grant_o, 2'b01);
    checkOutput("viol_s_req", s_req_o, 1);
    applyStimulus(0, 1'b0, 1'b1, 32'h400, 4'h3, 32'h0BADF00D);
    #1;
    checkOutput("viol_s_req_drop", s_req_o, 0);
    checkOutput("viol_no_ack", m_ack_o, 0);
    cycle(); #1;
    checkOutput("viol_grant_idle", grant_o, 0);
    applyStimulus(0, 1'b1, 1'b0, 32'h500, 4'hF, 32'h0);
    applyStimulus(1, 1'b1, 1'b1, 32'h600, 4'hF, 32'h66666666);
    cycle(); #1;
    checkOutput("viol_rr_kept", grant_o, 2'b01);

    // Reset in the middle of m0's read
    s_ack_i = 1'b1;
    #1;
    checkOutput("rrst_ack", m_ack_o, 2'b01);
    cycle();
    s_ack_i = 1'b0;
    #1;
    checkOutput("rrst_in_resp", grant_o, 2'b01);
    arst_i = 1'b1;
    #1;
    checkOutput("rrst_grant", grant_o, 0);
    checkOutput("rrst_s_req", s_req_o, 0);
    s_resp_i  = 1'b1;
    s_rdata_i = 32'h55AA55AA;
    #1;
    checkOutput("rrst_resp", m_resp_o, 0);
    checkOutput("rrst_rdata", m_rdata_o, 0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    cycle();
    arst_i = 1'b0;
    #1;
    checkOutput("rrst_post_resp0", m_resp_o, 0);
    cycle(); #1;
    checkOutput("rrst_post_resp1", m_resp_o, 0);
    checkOutput("rrst_post_grant", grant_o, 0);
    s_resp_i  = 1'b0;
    s_rdata_i = '0;
    applyStimulus(0, 1'b1, 1'b1, 32'h700, 4'hF, 32'h0);
    applyStimulus(1, 1'b1, 1'b1, 32'h800, 4'hF, 32'h0);
    cycle(); #1;
    checkOutput("rrst_rr0", grant_o, 2'b01);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    cycle(); #1;
    checkOutput("rrst_release", grant_o, 0);

`ifdef SIGMA_BUS_ARB_TIMEOUT_EN
    // Watchdog: m1 read never answered, abort in the 16th RESP cycle
    applyStimulus(1, 1'b1, 1'b0, 32'h900, 4'hF, 32'h0);
    cycle(); #1;
    checkOutput("to_grant", grant_o, 2'b10);
    s_ack_i = 1'b1;
    cycle();
    s_ack_i = 1'b0;
    repeat (14) cycle();
    #1;
    checkOutput("to_wait_resp", m_resp_o, 0);
    checkOutput("to_wait_err", err_o, 0);
    cycle(); #1;
    checkOutput("to_resp", m_resp_o, 2'b10);
    checkOutput("to_rdata", m_rdata_o, 32'hDEADBEEF);
    checkOutput("to_err", err_o, 1);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    cycle();
    s_resp_i = 1'b1;
    #1;
    checkOutput("to_err_pulse", err_o, 0);
    checkOutput("to_late_resp", m_resp_o, 0);
    checkOutput("to_grant_idle", grant_o, 0);
    s_resp_i = 1'b0;
`endif

    $display("%0d/%0d checks passed", num_passed, num_checks);
    $finish;
  end

endmodule
